// File: rtl/k_fifo_pkg.sv
// Shared constants and helpers for the k_fifo controller.
package k_fifo_pkg;

   localparam int unsigned K_FIFO_DEPTH_DEFAULT = 4;

   // Occupancy counter must represent 0..DEPTH, one bit wider than a pointer.
   function automatic int unsigned k_fifo_cnt_w(input int unsigned addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/k_fifo_ptr.sv
// Wrapping modulo-DEPTH pointer with increment enable and synchronous reset.
module k_fifo_ptr
   import k_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = K_FIFO_DEPTH_DEFAULT,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr
);

   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W-1:0] ptr_d;

   // Next pointer: advance on inc, wrap explicitly so non-power-of-two depths work.
   always_comb begin
      ptr_d = ptr_q;
      if (inc) begin
         ptr_d = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/k_fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM: pointers, occupancy, flags.
// Optional sticky overflow/underflow flags are enabled by defining K_FIFO_ERR_FLAGS_EN.
module k_fifo_ctrl
   import k_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = K_FIFO_DEPTH_DEFAULT,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic                            pop,
   output logic                            wen,
   output logic [ADDR_W-1:0]               waddr,
   output logic [ADDR_W-1:0]               raddr,
   output logic                            full,
   output logic                            empty,
   output logic [k_fifo_cnt_w(ADDR_W)-1:0] count
`ifdef K_FIFO_ERR_FLAGS_EN
   ,
   output logic                            ovf,
   output logic                            udf
`endif
);

   localparam int unsigned CNT_W = k_fifo_cnt_w(ADDR_W);

   logic             push_acc;
   logic             pop_acc;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             full_q;
   logic             full_d;
   logic             empty_q;
   logic             empty_d;

   // Accepted requests: flags gate illegal ops, reset cycle blocks everything.
   assign push_acc = push & ~full_q  & ~rst;
   assign pop_acc  = pop  & ~empty_q & ~rst;
   assign wen      = push_acc;

   k_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wptr (
      .clk (clk),
      .rst (rst),
      .inc (push_acc),
      .ptr (waddr)
   );

   k_fifo_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rptr (
      .clk (clk),
      .rst (rst),
      .inc (pop_acc),
      .ptr (raddr)
   );

   // Next occupancy and flags derived from it so flags line up with count.
   always_comb begin
      count_d = count_q;
      unique case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Occupancy and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

`ifdef K_FIFO_ERR_FLAGS_EN
   logic ovf_q;
   logic ovf_d;
   logic udf_q;
   logic udf_d;

   // Sticky error flags: raised by a rejected push/pop, cleared only by reset.
   always_comb begin
      ovf_d = ovf_q | (push & full_q);
      udf_d = udf_q | (pop & empty_q);
   end

   // Error flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign ovf = ovf_q;
   assign udf = udf_q;
`endif

endmodule

// File: tb/tb_k_fifo_ctrl.sv
// Self-checking bench for k_fifo_ctrl (DEPTH=4) with a RAM model and data scoreboard.
module tb_k_fifo_ctrl;

   logic       clk;
   logic       rst;
   logic       push;
   logic       pop;
   logic       wen;
   logic [1:0] waddr;
   logic [1:0] raddr;
   logic       full;
   logic       empty;
   logic [2:0] count;
`ifdef K_FIFO_ERR_FLAGS_EN
   logic       ovf;
   logic       udf;
`endif

   k_fifo_ctrl #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wen   (wen),
      .waddr (waddr),
      .raddr (raddr),
      .full  (full),
      .empty (empty),
      .count (count)
`ifdef K_FIFO_ERR_FLAGS_EN
      ,
      .ovf   (ovf),
      .udf   (udf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_cnt = 0;
   int m_w   = 0;
   int m_r   = 0;
   bit m_pacc;
   bit m_qacc;
   bit m_ovf = 0;
   bit m_udf = 0;
   logic [31:0] ram [4];
   logic [31:0] sb [$];

   // Drive inputs on the falling edge; model the RAM write and check the popped head.
   task automatic set(input logic p, input logic q, input logic r);
      logic [31:0] d;
      logic [31:0] exp;
      @(negedge clk);
      rst  = r;
      push = p;
      pop  = q;
      m_pacc = p && (m_cnt != 4) && !r;
      m_qacc = q && (m_cnt != 0) && !r;
      #2;
      if (m_qacc) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_underrun: model popped with empty scoreboard");
         end else begin
            exp = sb.pop_front();
            if (ram[raddr] !== exp) begin
               bad++;
               $display("FAIL sb_data: got %h want %h (raddr=%0d)", ram[raddr], exp, raddr);
            end
         end
      end
      if (m_pacc) begin
         d = $urandom;
         ram[waddr] = d;
         sb.push_back(d);
      end
   endtask

   // Clock edge and model update; returns #1 after the edge.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_cnt = 0; m_w = 0; m_r = 0; m_ovf = 0; m_udf = 0;
         sb.delete();
      end else begin
         if (push && m_cnt == 4) m_ovf = 1;
         if (pop && m_cnt == 0)  m_udf = 1;
         if (m_pacc) m_w = (m_w + 1) % 4;
         if (m_qacc) m_r = (m_r + 1) % 4;
         m_cnt = m_cnt + int'(m_pacc) - int'(m_qacc);
      end
      #1;
   endtask

   task automatic test_reset();
      set(0, 0, 1);
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", empty); end
      total++; if (full !== 1'b0)  begin bad++; $display("FAIL rst_full: got %b want 0", full); end
      total++; if (waddr !== 2'd0 || raddr !== 2'd0) begin bad++; $display("FAIL rst_ptrs: got w=%0d r=%0d want 0 0", waddr, raddr); end
`ifdef K_FIFO_ERR_FLAGS_EN
      total++; if (ovf !== 1'b0 || udf !== 1'b0) begin bad++; $display("FAIL rst_err: got ovf=%b udf=%b want 0 0", ovf, udf); end
`endif
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         set(1, 0, 0);
         total++; if (wen !== 1'b1) begin bad++; $display("FAIL fill_wen[%0d]: got %b want 1", i, wen); end
         total++; if (waddr !== 2'(i)) begin bad++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, waddr, i); end
         tick();
         total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
         if (i == 0) begin
            total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty: got %b want 0", empty); end
         end
         if (i < 3) begin
            total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_early[%0d]: got %b want 0", i, full); end
         end
      end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b want 1", full); end
   endtask

   task automatic test_overflow();
      set(1, 0, 0);
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL ovf_wen: got %b want 0", wen); end
      tick();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
      total++; if (waddr !== 2'd0) begin bad++; $display("FAIL ovf_waddr: got %0d want 0", waddr); end
      for (int i = 0; i < 3; i++) begin
         set(0, 0, 0);
         tick();
`ifdef K_FIFO_ERR_FLAGS_EN
         total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, ovf); end
`endif
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         set(0, 1, 0);
         total++; if (raddr !== 2'(i)) begin bad++; $display("FAIL drain_raddr[%0d]: got %0d want %0d", i, raddr, i); end
         tick();
         total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 3 - i); end
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
      set(0, 1, 0);
      tick();
      total++; if (raddr !== 2'd0) begin bad++; $display("FAIL udf_raddr: got %0d want 0", raddr); end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL udf_count: got %0d want 0", count); end
`ifdef K_FIFO_ERR_FLAGS_EN
      total++; if (udf !== 1'b1) begin bad++; $display("FAIL udf_flag: got %b want 1", udf); end
      total++; if (ovf !== 1'(m_ovf)) begin bad++; $display("FAIL udf_ovf_keep: got %b want %b", ovf, m_ovf); end
`endif
   endtask

   task automatic test_back_to_back();
      set(1, 0, 0); tick();
      set(1, 0, 0); tick();
      for (int i = 0; i < 10; i++) begin
         set(1, 1, 0);
         total++; if (wen !== 1'b1) begin bad++; $display("FAIL b2b_wen[%0d]: got %b want 1", i, wen); end
         total++; if (waddr !== 2'(m_w) || raddr !== 2'(m_r)) begin bad++; $display("FAIL b2b_ptrs[%0d]: got w=%0d r=%0d want %0d %0d", i, waddr, raddr, m_w, m_r); end
         tick();
         total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, count); end
      end
      // 2+10 writes and 10 reads modulo 4
      total++; if (waddr !== 2'd0 || raddr !== 2'd2) begin bad++; $display("FAIL b2b_wrap: got w=%0d r=%0d want 0 2", waddr, raddr); end
   endtask

   task automatic test_simul_edges();
      set(1, 1, 0);
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL se_empty_wen: got %b want 1", wen); end
      tick();
      total++; if (count !== 3'd1 || raddr !== 2'd0) begin bad++; $display("FAIL se_empty: got cnt=%0d r=%0d want 1 0", count, raddr); end
      for (int i = 0; i < 3; i++) begin set(1, 0, 0); tick(); end
      total++; if (full !== 1'b1) begin bad++; $display("FAIL se_fill: got full=%b want 1", full); end
      set(1, 1, 0);
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL se_full_wen: got %b want 0", wen); end
      tick();
      total++; if (count !== 3'd3 || raddr !== 2'd1 || waddr !== 2'd0) begin bad++; $display("FAIL se_full: got cnt=%0d r=%0d w=%0d want 3 1 0", count, raddr, waddr); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin set(1, 0, 0); tick(); end
      total++; if (count !== 3'd3) begin bad++; $display("FAIL rm_pre: got %0d want 3", count); end
      set(1, 0, 1);
      total++; if (wen !== 1'b0) begin bad++; $display("FAIL rm_wen: got %b want 0", wen); end
      tick();
      total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rm_flags: got cnt=%0d e=%b f=%b want 0 1 0", count, empty, full); end
      total++; if (waddr !== 2'd0 || raddr !== 2'd0) begin bad++; $display("FAIL rm_ptrs: got w=%0d r=%0d want 0 0", waddr, raddr); end
      set(0, 0, 0); tick();
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_reset();
      test_back_to_back();
      test_reset();
      test_simul_edges();
      test_reset();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
